// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding,
// parameter defaults and the index-width helper.
package fifo_write_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int N_DEF         = 4;
  localparam int W_DEF         = 16;
  localparam int BURST_MAX_DEF = 4;

  // Width of the per-grant word counter; BURST_MAX is limited to 1..15.
  localparam int CNT_W = 4;

  // Index width for N requesters, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W_DEF = id_width(N_DEF);

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Bundle of requester handshake and FIFO write-port signals.
// slave is the arbiter's view, master is the requester/FIFO side.
interface fifo_write_arbiter_if
  import fifo_write_arbiter_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
);
  localparam int ID_W = id_width(N);

  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic            w_full;
  logic            fifo_wr_en;
  logic [W-1:0]    fifo_wr_data;
  logic [ID_W-1:0] grant_id;
  logic            busy;

  modport slave (
    input  req_valid, req_data, w_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
  );

  modport master (
    output req_valid, req_data, w_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
  );

endinterface

// File: rtl/fifo_write_arbiter_rr_priority_select.sv
// Rotating-priority selector: returns the first requester with a set
// valid bit, scanning upward from rr_ptr and wrapping past N-1.
module rr_priority_select
  import fifo_write_arbiter_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req_valid,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [ID_W-1:0] grant_idx,
  output logic            found
);

  logic [2*N-1:0] doubled;
  logic [2*N-1:0] rotated;
  int             offset;
  int             sum;

  // Rotate so that bit 0 of the low half corresponds to requester rr_ptr.
  assign doubled = {req_valid, req_valid};
  assign rotated = doubled >> rr_ptr;

  // Walk offsets from far to near so the nearest set bit is the last written.
  always_comb begin
    offset    = 0;
    found     = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        offset = k;
        found  = 1'b1;
      end
    end
    sum = int'(rr_ptr) + offset;
    if (sum >= N) begin
      sum = sum - N;
    end
    grant_idx = ID_W'(sum);
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that lets N requesters share one FIFO write port,
// granting bursts of up to BURST_MAX words with a one-cycle arbitration gap.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int W         = W_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic                write_clk,
  input  logic                reset,
  fifo_write_arbiter_if.slave bus
);

  localparam int              ID_W        = id_width(N);
  localparam logic [ID_W-1:0] LAST_ID     = ID_W'(N - 1);
  localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(BURST_MAX);

  arb_state_t       state_reg;
  logic [ID_W-1:0]  grant_id_reg;
  logic [ID_W-1:0]  rr_ptr_reg;
  logic [CNT_W-1:0] burst_cnt_reg;
  logic             busy_reg;

  logic [ID_W-1:0]  sel_idx;
  logic             sel_found;
  logic [ID_W-1:0]  rr_ptr_next;
  logic [CNT_W-1:0] burst_cnt_next;
  logic             in_burst;
  logic             grant_valid;
  logic             transfer;
  logic [N-1:0]     ready_vec;
  logic [W-1:0]     wr_data;

  rr_priority_select #(
    .N    (N),
    .ID_W (ID_W)
  ) u_select (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr_reg),
    .grant_idx (sel_idx),
    .found     (sel_found)
  );

  assign in_burst       = (state_reg == BURST);
  assign grant_valid    = bus.req_valid[grant_id_reg];
  // A full FIFO blocks the write in the same cycle it rises.
  assign transfer       = in_burst & grant_valid & ~bus.w_full;
  assign burst_cnt_next = burst_cnt_reg + CNT_W'(1);
  assign rr_ptr_next    = (grant_id_reg == LAST_ID) ? '0 : grant_id_reg + ID_W'(1);

  // Only the grantee sees ready, and only while the FIFO has room.
  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign ready_vec[gi] = in_burst & (grant_id_reg == ID_W'(gi)) & ~bus.w_full;
  end

  // Steer the grantee's word to the FIFO; valid whenever a grant is registered.
  always_comb begin
    wr_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_id_reg == ID_W'(i)) begin
        wr_data = bus.req_data[i*W +: W];
      end
    end
  end

  // Arbitration FSM: pick a grantee in IDLE, count words in BURST, rotate on exit.
  always_ff @(posedge write_clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      grant_id_reg  <= '0;
      burst_cnt_reg <= '0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (sel_found) begin
            grant_id_reg  <= sel_idx;
            burst_cnt_reg <= '0;
            busy_reg      <= 1'b1;
            state_reg     <= BURST;
          end
        end
        BURST: begin
          if (transfer) begin
            burst_cnt_reg <= burst_cnt_next;
            if (burst_cnt_next == BURST_LIMIT) begin
              rr_ptr_reg <= rr_ptr_next;
              busy_reg   <= 1'b0;
              state_reg  <= IDLE;
            end
          end else if (!bus.w_full && !grant_valid) begin
            // Grantee ran dry with room in the FIFO: give up the grant early.
            rr_ptr_reg <= rr_ptr_next;
            busy_reg   <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready    = ready_vec;
  assign bus.fifo_wr_en   = transfer;
  assign bus.fifo_wr_data = wr_data;
  assign bus.grant_id     = grant_id_reg;
  assign bus.busy         = busy_reg;

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters sharing the FIFO write port.
REQ-002 Parameter W, default 16: data word width, equal to the FIFO word width.
REQ-003 Parameter BURST_MAX, default 4: maximum words per grant, 1..15.
REQ-004 write_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  N  per-requester word-available flag.
REQ-007 req_data  input  N*W  requester i word on bits [i*W+W-1 : i*W].
REQ-008 req_ready  output  N  per-requester accept strobe.
REQ-009 w_full  input  1  FIFO full flag, write-clock domain.
REQ-010 fifo_wr_en  output  1  write strobe to the FIFO write port.
REQ-011 fifo_wr_data  output  W  word to the FIFO write port.
REQ-012 grant_id  output  clog2(N)  index of the current grantee.
REQ-013 busy  output  1  high while a grant is held.

Function
REQ-014 FSM has two states: IDLE and BURST.
REQ-015 IDLE: if any req_valid bit is high, select the first set bit scanning upward from rr_ptr with wrap. Register it in grant_id. Clear burst_cnt. Enter BURST on the next edge.
REQ-016 IDLE with no valid request: remain in IDLE; grant_id holds its last value.
REQ-017 req_ready[i] = (state==BURST) & (i==grant_id) & ~w_full. This is combinational, and all other bits are 0.
REQ-018 A transfer occurs when req_valid[grant_id] & req_ready[grant_id] are both high.
REQ-019 fifo_wr_en equals the transfer term and is combinational. This gives zero-cycle latency from accept to FIFO write.
REQ-020 fifo_wr_data = req_data slice of grant_id, at all times.
REQ-021 Each transfer increments burst_cnt, 4 bits wide.
REQ-022 BURST exits to IDLE after the transfer that makes burst_cnt reach BURST_MAX.
REQ-023 BURST also exits to IDLE on any cycle where req_valid[grant_id] is low while w_full is low.
REQ-024 On every BURST exit, set rr_ptr = grant_id+1, wrapping from N-1 to 0.
REQ-025 w_full high during BURST: no transfer, burst_cnt holds, state stays BURST, grant is kept regardless of req_valid.
REQ-026 w_full rising in the same cycle as a would-be transfer: no transfer that cycle.
REQ-027 Arbitration costs exactly one IDLE cycle between consecutive bursts. Back-to-back grants to different requesters are therefore separated by one cycle.
REQ-028 A requester that drops req_valid while not granted loses nothing. Its next request is served in round-robin order.
REQ-029 busy = (state==BURST).

Reset
REQ-030 Reset asserted at any time, including mid-burst, forces the following on the same cycle asynchronously: state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, busy=0, req_ready=0, fifo_wr_en=0.
REQ-031 A word presented in a cycle truncated by reset is not written.
REQ-032 The first arbitration after reset release starts scanning from requester 0.

Structure
REQ-033 A shared package holds the FSM state encoding (IDLE=0, BURST=1), the defaults for N, W and BURST_MAX, and the clog2 helper constant.
REQ-034 The rotating-priority selector is a single sub-module, rr_priority_select. It takes req_valid and rr_ptr and returns grant index plus found flag, and is purely combinational.
REQ-035 The FSM, counter, rr_ptr and output muxing stay in fifo_write_arbiter.

Verification
REQ-036 Stimulus: reset, then req_valid=0001 held high, w_full=0. Response: requester 0 words written in bursts of 4 with one idle cycle between bursts; fifo_wr_en pattern is 0,1,1,1,1,0,1,1,1,1.
REQ-037 Stimulus: all four requesters valid continuously. Response: grant_id sequence is 0,1,2,3,0, each burst 4 words, and every fifo_wr_data matches the granted slice.
REQ-038 Stimulus: w_full held high for 5 cycles after the 2nd word of requester 1's burst. Response: no fifo_wr_en during the stall, grant_id stays 1, then exactly 2 more words are written.
REQ-039 Stimulus: requester 2 drops req_valid after 1 word while requester 3 is valid. Response: BURST exits, one IDLE cycle, grant_id=3.
REQ-040 Stimulus: reset pulsed mid-burst after word 2. Response: fifo_wr_en=0 and busy=0 immediately; after release the first grant goes to the lowest valid index.
